lathe_cycle_sequencer: RTL

Supervisory controller for the retrofitted manual lathe: sequences spindle enable, spin-up delay, carriage feed toward a forward limit, dwell, and retract to home, with emergency-stop, guard interlock and motion-timeout protection. It extends the single start-delayed control output of the existing PLC-style block into a full auto cycle, and adds a manual jog mode. It drives the spindle contactor and feed-motor direction outputs directly and reports state, fault and completed-cycle count to the status logic.

---
 rtl/lathe_pkg.sv | 31 +++
 rtl/lathe_phase_timer.sv | 33 +++
 rtl/lathe_cycle_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lathe_pkg.sv
// Shared definitions for the lathe cycle sequencer: state encoding,
// fault codes and the default phase durations at a 50 MHz clock.
package lathe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SPINUP  = 3'd1,
        ST_FEED    = 3'd2,
        ST_DWELL   = 3'd3,
        ST_RETRACT = 3'd4,
        ST_MANUAL  = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ESTOP   = 2'd1;
    localparam logic [1:0] FC_GUARD   = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

    localparam int SPINUP_CYCLES_DEF  = 150_000_000;
    localparam int DWELL_CYCLES_DEF   = 50_000_000;
    localparam int MOTION_TIMEOUT_DEF = 500_000_000;

    // Largest of three presets; sizes the shared phase timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lathe_phase_timer.sv
// Phase timer: counts cycles spent in the current FSM state and flags
// when the selected preset has been reached.
module lathe_phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic [TW-1:0] i_preset,
    output logic          o_done
);

    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt;

    // i_clr is high during the first cycle of a new state. That cycle is
    // count 0, so the counter loads 1 and the visible count is masked to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= TW'(1);
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign w_cnt  = i_clr ? '0 : r_cnt;
    // Done in the last cycle of the phase so the FSM leaves after exactly
    // i_preset cycles in the state.
    assign o_done = (w_cnt >= (i_preset - TW'(1)));

endmodule

// File: rtl/lathe_cycle_sequencer.sv
// Lathe supervisory sequencer: auto cycle (spin-up, feed, dwell, retract),
// manual jog mode, and estop / guard / motion-timeout fault handling.
module lathe_cycle_sequencer
    import lathe_pkg::*;
#(
    parameter int SPINUP_CYCLES  = SPINUP_CYCLES_DEF,
    parameter int DWELL_CYCLES   = DWELL_CYCLES_DEF,
    parameter int MOTION_TIMEOUT = MOTION_TIMEOUT_DEF,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             auto,
    input  logic             man,
    input  logic             estop,
    input  logic             guard_ok,
    input  logic             limit_fwd,
    input  logic             limit_home,
    input  logic             jog_fwd,
    input  logic             jog_rev,
    input  logic             fault_clr,
    output logic             spindle_en,
    output logic             feed_fwd,
    output logic             feed_rev,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int TW = $clog2(max3(SPINUP_CYCLES, DWELL_CYCLES, MOTION_TIMEOUT)) + 1;

    state_t           r_state;
    logic             r_start_q;
    logic             r_tmr_clr;
    logic             r_abort;
    logic             r_spindle;
    logic             r_fwd;
    logic             r_rev;
    logic             r_busy;
    logic             r_fault;
    logic [1:0]       r_code;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_nxt;
    logic [1:0]       w_nxt_code;
    logic             w_inc;
    logic             w_abort_set;
    logic [TW-1:0]    w_preset;
    logic             w_done;
    logic             w_start_edge;
    logic             w_jog_fwd;
    logic             w_jog_rev;

    assign w_start_edge = start & ~r_start_q;
    // Jog requests cancel each other and stop at the matching limit.
    assign w_jog_fwd    = jog_fwd & ~jog_rev & ~limit_fwd;
    assign w_jog_rev    = jog_rev & ~jog_fwd & ~limit_home;

    // Preset for the phase timer, chosen by the state it is timing.
    always_comb begin
        w_preset = TW'(MOTION_TIMEOUT);
        case (r_state)
            ST_SPINUP: w_preset = TW'(SPINUP_CYCLES);
            ST_DWELL:  w_preset = TW'(DWELL_CYCLES);
            default:   ;
        endcase
    end

    lathe_phase_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (r_tmr_clr),
        .i_preset (w_preset),
        .o_done   (w_done)
    );

    // Start input history for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_start_q <= 1'b0;
        else        r_start_q <= start;
    end

    // Transition rules; active states honour estop > guard > stop > timer/limit.
    always_comb begin
        w_nxt       = r_state;
        w_nxt_code  = r_code;
        w_inc       = 1'b0;
        w_abort_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (estop) begin
                    w_nxt      = ST_FAULT;
                    w_nxt_code = FC_ESTOP;
                end else if (w_start_edge && guard_ok && (auto ^ man)) begin
                    w_nxt = auto ? ST_SPINUP : ST_MANUAL;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !estop && guard_ok) begin
                    w_nxt      = ST_IDLE;
                    w_nxt_code = FC_NONE;
                end
            end
            default: begin
                if (estop) begin
                    w_nxt      = ST_FAULT;
                    w_nxt_code = FC_ESTOP;
                end else if (!guard_ok) begin
                    w_nxt      = ST_FAULT;
                    w_nxt_code = FC_GUARD;
                end else begin
                    case (r_state)
                        ST_SPINUP: begin
                            if (stop)        w_nxt = ST_IDLE;
                            else if (w_done) w_nxt = ST_FEED;
                        end
                        ST_FEED: begin
                            if (stop) begin
                                w_nxt       = ST_RETRACT;
                                w_abort_set = 1'b1;
                            end else if (limit_fwd) begin
                                w_nxt = ST_DWELL;
                            end else if (w_done) begin
                                w_nxt      = ST_FAULT;
                                w_nxt_code = FC_TIMEOUT;
                            end
                        end
                        ST_DWELL: begin
                            if (stop) begin
                                w_nxt       = ST_RETRACT;
                                w_abort_set = 1'b1;
                            end else if (w_done) begin
                                w_nxt = ST_RETRACT;
                            end
                        end
                        ST_RETRACT: begin
                            // Stop is ignored here: the carriage must get home.
                            if (limit_home) begin
                                w_nxt = ST_IDLE;
                                w_inc = ~r_abort;
                            end else if (w_done) begin
                                w_nxt      = ST_FAULT;
                                w_nxt_code = FC_TIMEOUT;
                            end
                        end
                        ST_MANUAL: begin
                            if (stop || !man || auto) w_nxt = ST_IDLE;
                        end
                        default: w_nxt = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    // State, counter and outputs, all decoded from the next state so they
    // change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_code    <= FC_NONE;
            r_tmr_clr <= 1'b1;
            r_abort   <= 1'b0;
            r_cnt     <= '0;
            r_spindle <= 1'b0;
            r_fwd     <= 1'b0;
            r_rev     <= 1'b0;
            r_busy    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_code    <= w_nxt_code;
            r_tmr_clr <= (w_nxt != r_state);
            if (r_state == ST_IDLE) r_abort <= 1'b0;
            else if (w_abort_set)   r_abort <= 1'b1;
            if (w_inc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
            r_spindle <= (w_nxt == ST_SPINUP) || (w_nxt == ST_FEED) || (w_nxt == ST_DWELL)
                         || (w_nxt == ST_RETRACT) || (w_nxt == ST_MANUAL);
            r_fwd     <= (w_nxt == ST_FEED) || ((w_nxt == ST_MANUAL) && w_jog_fwd);
            r_rev     <= (w_nxt == ST_RETRACT) || ((w_nxt == ST_MANUAL) && w_jog_rev);
            r_busy    <= (w_nxt != ST_IDLE) && (w_nxt != ST_FAULT);
            r_fault   <= (w_nxt == ST_FAULT);
        end
    end

    assign spindle_en = r_spindle;
    assign feed_fwd   = r_fwd;
    assign feed_rev   = r_rev;
    assign busy       = r_busy;
    assign fault      = r_fault;
    assign fault_code = r_code;
    assign state      = r_state;
    assign cycle_cnt  = r_cnt;

endmodule
